// File: rtl/iir_tap_scheduler.sv
// iir_tap_scheduler: 5th-order direct-form-I IIR computed on one time-shared signed MAC
module iir_tap_scheduler #(
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int OSHIFT = 12,
  parameter int ACCW   = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_err,
  input  logic          hist_clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sat,
  output logic          busy
);
  typedef enum logic [2:0] {IDLE, MAC_B, MAC_A, SCALE, OUT} state_t;
  localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [ACCW-1:0] HALF = {{(ACCW-OSHIFT){1'b0}}, 1'b1, {(OSHIFT-1){1'b0}}};
  localparam logic signed [CW-1:0]   ONE  = {{(CW-OSHIFT-1){1'b0}}, 1'b1, {OSHIFT{1'b0}}};
  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [CW-1:0]   b_q [6];
  logic signed [CW-1:0]   b_d [6];
  logic signed [CW-1:0]   a_q [5];
  logic signed [CW-1:0]   a_d [5];
  logic signed [DW-1:0]   x_q [6];
  logic signed [DW-1:0]   x_d [6];
  logic signed [DW-1:0]   y_q [5];
  logic signed [DW-1:0]   y_d [5];
  logic [DW-1:0]          out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d, cfg_err_q, cfg_err_d;
  logic                   idle, bad_addr;
  logic signed [CW-1:0]   coef;
  logic signed [DW-1:0]   samp;
  logic signed [CW+DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext, rnd, shf;
  assign idle      = state_q == IDLE;
  assign in_ready  = idle;
  assign busy      = !idle;
  assign out_valid = state_q == OUT;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign cfg_err   = cfg_err_q;
  // Shared MAC operand select (a/y taps in MAC_A, b/x taps otherwise) and output rounding
  always_comb begin
    coef     = (state_q == MAC_A) ? a_q[cnt_q] : b_q[cnt_q];
    samp     = (state_q == MAC_A) ? y_q[cnt_q] : x_q[cnt_q];
    prod     = coef * samp;
    prod_ext = {{(ACCW-CW-DW){prod[CW+DW-1]}}, prod};
    rnd      = acc_q + HALF;
    shf      = rnd >>> OSHIFT;
  end
  // Next-state: coefficient writes, history maintenance and the tap sequence
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    a_d        = a_q;
    x_d        = x_q;
    y_d        = y_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    bad_addr   = cfg_sel ? (cfg_addr == 3'd0 || cfg_addr > 3'd5) : (cfg_addr > 3'd5);
    cfg_err_d  = cfg_we && (!idle || bad_addr);
    if (cfg_we && idle && !bad_addr) begin
      if (cfg_sel) a_d[cfg_addr - 3'd1] = cfg_data;
      else b_d[cfg_addr] = cfg_data;
    end
    case (state_q)
      IDLE: begin
        if (hist_clr) begin
          for (int i = 0; i < 6; i++) x_d[i] = '0;
          for (int i = 0; i < 5; i++) y_d[i] = '0;
        end
        if (in_valid) begin
          for (int i = 1; i < 6; i++) x_d[i] = hist_clr ? '0 : x_q[i-1];
          x_d[0]  = in_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MAC_B;
        end
      end
      MAC_B: begin
        acc_d   = acc_q + prod_ext;
        cnt_d   = (cnt_q == 3'd5) ? 3'd0 : cnt_q + 3'd1;
        state_d = (cnt_q == 3'd5) ? MAC_A : MAC_B;
      end
      MAC_A: begin
        acc_d   = acc_q - prod_ext;
        cnt_d   = (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
        state_d = (cnt_q == 3'd4) ? SCALE : MAC_A;
      end
      SCALE: begin
        out_sat_d  = (shf > YMAX) || (shf < YMIN);
        out_data_d = (shf > YMAX) ? YMAX[DW-1:0] : (shf < YMIN) ? YMIN[DW-1:0] : shf[DW-1:0];
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) begin
          for (int i = 1; i < 5; i++) y_d[i] = y_q[i-1];
          y_d[0]  = out_data_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers; reset restores the passthrough coefficient set and clears histories
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      for (int i = 0; i < 6; i++) b_q[i] <= (i == 0) ? ONE : '0;
      for (int i = 0; i < 5; i++) a_q[i] <= '0;
      for (int i = 0; i < 6; i++) x_q[i] <= '0;
      for (int i = 0; i < 5; i++) y_q[i] <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      a_q        <= a_d;
      x_q        <= x_d;
      y_q        <= y_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      cfg_err_q  <= cfg_err_d;
    end
  end
endmodule

// File: tb/tb_iir_tap_scheduler.sv
// tb_iir_tap_scheduler: directed and random stimulus against an arithmetic IIR model
module tb_iir_tap_scheduler;
  logic clk = 0, rst_n = 0, cfg_we = 0, cfg_sel = 0, hist_clr = 0, in_valid = 0, out_ready = 0;
  logic [2:0] cfg_addr = 0;
  logic [15:0] cfg_data = 0, in_data = 0;
  logic cfg_err, in_ready, out_valid, out_sat, busy;
  logic [15:0] out_data;
  int tests = 0, fails = 0, cyc = 0, due = 0, acc_cyc = 0, last_lat = 0, nout = 0;
  longint mb [6], ma [6], mx [6], my [6];
  bit pend, esat, eerr, ov_prev, idle, vexp, bad, got, last_sat;
  logic [15:0] ey, last_y;

  iir_tap_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .hist_clr(hist_clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: sim time %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string n, input longint a, input longint e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic void mreset();
    for (int i = 0; i < 6; i++) begin mb[i] = 0; ma[i] = 0; mx[i] = 0; my[i] = 0; end
    mb[0] = 4096;
    pend = 0; eerr = 0; ov_prev = 0;
  endfunction

  function automatic void maccept();
    longint acc, r, q;
    for (int i = 5; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = $signed(in_data);
    acc = 0;
    for (int i = 0; i < 6; i++) acc += mb[i] * mx[i];
    for (int k = 1; k < 6; k++) acc -= ma[k] * my[k];
    r = acc + 2048;
    q = (r >= 0) ? r / 4096 : -((-r + 4095) / 4096);
    esat = (q > 32767) || (q < -32768);
    q = (q > 32767) ? 32767 : (q < -32768) ? -32768 : q;
    ey = 16'(q);
    pend = 1; due = cyc + 13; acc_cyc = cyc;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      mreset();
    end else begin
      idle = !pend;
      vexp = pend && (cyc >= due);
      chk("in_ready", in_ready, idle);
      chk("busy", busy, !idle);
      chk("out_valid", out_valid, vexp);
      chk("cfg_err", cfg_err, eerr);
      if (vexp) begin
        chk("out_data", out_data, ey);
        chk("out_sat", out_sat, esat);
      end
      if (out_valid && !ov_prev) last_lat = cyc - acc_cyc;
      ov_prev = out_valid;
      bad = cfg_sel ? (cfg_addr == 0 || cfg_addr > 5) : (cfg_addr > 5);
      eerr = cfg_we && (!idle || bad);
      if (idle && cfg_we && !bad) begin
        if (cfg_sel) ma[cfg_addr] = $signed(cfg_data);
        else mb[cfg_addr] = $signed(cfg_data);
      end
      if (idle && hist_clr)
        for (int i = 0; i < 6; i++) begin mx[i] = 0; my[i] = 0; end
      if (idle && in_valid) maccept();
      else if (vexp && out_ready) begin
        for (int k = 5; k > 1; k--) my[k] = my[k-1];
        my[1] = $signed(ey);
        pend = 0; last_y = out_data; last_sat = out_sat; nout++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input bit sel, input logic [2:0] addr, input logic [15:0] d);
    cfg_we = 1; cfg_sel = sel; cfg_addr = addr; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1; in_data = d; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    tick();
    in_valid = 0;
    chk("accept_timeout", got, 1);
  endtask

  task automatic drain();
    int n0;
    n0 = nout; out_ready = 1; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      if (nout > n0) got = 1;
    end
    #1;
    chk("drain_timeout", got, 1);
  endtask

  task automatic run(input string n, input logic [15:0] d, input logic [15:0] e, input bit s);
    push(d);
    drain();
    chk(n, last_y, e);
    chk({n, "_sat"}, last_sat, s);
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1;
    tick();
    out_ready = 1;
    run("s1_pass", 16'h1234, 16'h1234, 0);
    chk("s1_latency", last_lat, 13);
    cfg(0, 0, 16'h0800);
    run("s2_half", 16'h2000, 16'h1000, 0);
    run("s2_round", 16'h0003, 16'h0002, 0);
    push(16'hFFFD);
    drain();
    cfg(0, 0, 16'h1000);
    cfg(1, 1, 16'hF800);
    hist_clr = 1; tick(); hist_clr = 0;
    run("s3_y0", 16'h1000, 16'h1000, 0);
    run("s3_y1", 16'h0000, 16'h0800, 0);
    run("s3_y2", 16'h0000, 16'h0400, 0);
    run("s3_y3", 16'h0000, 16'h0200, 0);
    run("s3_y4", 16'h0000, 16'h0100, 0);
    cfg(1, 1, 16'h0000);
    cfg(0, 0, 16'h7FFF);
    run("s4_pos", 16'h7FFF, 16'h7FFF, 1);
    run("s4_neg", 16'h8000, 16'h8000, 1);
    cfg(0, 0, 16'h1000);
    cfg(0, 6, 16'h1111);
    @(negedge clk);
    chk("bad_addr_err", cfg_err, 1);
    tick();
    out_ready = 0;
    push(16'h0555);
    in_valid = 1; in_data = 16'h0777;
    for (int i = 0; i < 35; i++) begin
      cfg_we = (i == 20); cfg_sel = 0; cfg_addr = 0; cfg_data = 16'h0800;
      tick();
      cfg_we = 0;
      if (i == 20) begin
        @(negedge clk);
        chk("s5_busy_err", cfg_err, 1);
      end
    end
    @(negedge clk);
    chk("s5_hold_valid", out_valid, 1);
    chk("s5_hold_data", out_data, 16'h0555);
    chk("s5_hold_ready", in_ready, 0);
    tick();
    in_valid = 0;
    drain();
    chk("s5_out", last_y, 16'h0555);
    run("s5_coef_kept", 16'h0100, 16'h0100, 0);
    cfg(0, 0, 16'h0800);
    push(16'h4321);
    repeat (7) tick();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    repeat (20) tick();
    run("s6_pass", 16'h1234, 16'h1234, 0);
    chk("s6_latency", last_lat, 13);
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom % 4) != 0;
      in_valid  = $urandom % 2;
      in_data   = 16'($urandom);
      cfg_we    = ($urandom % 12) == 0;
      cfg_sel   = $urandom % 2;
      cfg_addr  = 3'($urandom % 8);
      cfg_data  = cfg_sel ? 16'($urandom_range(0, 2047)) - 16'd1024 : 16'($urandom_range(0, 8191)) - 16'd4096;
      hist_clr  = ($urandom % 32) == 0;
      tick();
    end
    in_valid = 0; cfg_we = 0; hist_clr = 0; out_ready = 1;
    repeat (30) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
